fft8_seq_ctrl: RTL and testbench

- Sequencer for one shared registered radix-2 DIF butterfly unit (1-cycle latency, outputs valid the cycle after start=1; twiddle multiply keeps low 16 bits).
- Buffers one 8-point complex frame, issues the 12 butterflies (3 stages x 4), writes results back in place, then streams the 8 bins out.
- Also owns the 4-entry twiddle table driven onto the butterfly w inputs.

---
 rtl/fft8_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft8_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_seq_ctrl.sv
// Sequencer for one shared registered radix-2 DIF butterfly: buffers an 8-point frame, runs 3x4 butterflies in place, streams bins.
// Optional FFT8_NATURAL_ORDER_EN: emit bins in natural frequency order instead of buffer (bit-reversed) order.
module fft8_seq_ctrl #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_i,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_r,
   output logic [DW-1:0] out_i,
   output logic [2:0]    out_bin,
   output logic          out_last,
   output logic          busy,
   input  logic          tw_we,
   input  logic [1:0]    tw_addr,
   input  logic [DW-1:0] tw_wr_r,
   input  logic [DW-1:0] tw_wr_i,
   output logic          bf_start,
   output logic [DW-1:0] bf_x1_r,
   output logic [DW-1:0] bf_x1_i,
   output logic [DW-1:0] bf_x2_r,
   output logic [DW-1:0] bf_x2_i,
   output logic [DW-1:0] bf_w_r,
   output logic [DW-1:0] bf_w_i,
   input  logic [DW-1:0] bf_y1_r,
   input  logic [DW-1:0] bf_y1_i,
   input  logic [DW-1:0] bf_y2_r,
   input  logic [DW-1:0] bf_y2_i
);
   typedef enum logic [1:0] {LOAD, RUN, DRAIN, OUT} state_t;

   state_t        state;
   logic [2:0]    cnt, k;
   logic [1:0]    stage, j;
   logic          pend_v;
   logic [2:0]    pend_a, pend_b;
   logic [DW-1:0] mem_r [8];
   logic [DW-1:0] mem_i [8];
   logic [DW-1:0] tw_r [4];
   logic [DW-1:0] tw_i [4];
   logic [2:0]    ia, ib, rd_idx, bin_k;
   logic [1:0]    itw;

   function automatic logic [2:0] bitrev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   // Pair addresses and twiddle index for butterfly j of the current stage (span 4>>stage).
   always_comb begin
      ia  = '0;
      ib  = '0;
      itw = '0;
      case (stage)
         2'd0: begin ia = {1'b0, j}; ib = {1'b1, j}; itw = j; end
         2'd1: begin ia = {j[1], 1'b0, j[0]}; ib = {j[1], 1'b1, j[0]}; itw = {j[0], 1'b0}; end
         default: begin ia = {j, 1'b0}; ib = {j, 1'b1}; itw = 2'd0; end
      endcase
   end

`ifdef FFT8_NATURAL_ORDER_EN
   assign rd_idx = bitrev3(k);
   assign bin_k  = k;
`else
   assign rd_idx = k;
   assign bin_k  = bitrev3(k);
`endif

   assign bf_x1_r = bf_start ? mem_r[ia]  : '0;
   assign bf_x1_i = bf_start ? mem_i[ia]  : '0;
   assign bf_x2_r = bf_start ? mem_r[ib]  : '0;
   assign bf_x2_i = bf_start ? mem_i[ib]  : '0;
   assign bf_w_r  = bf_start ? tw_r[itw]  : '0;
   assign bf_w_i  = bf_start ? tw_i[itw]  : '0;
   assign out_r   = out_valid ? mem_r[rd_idx] : '0;
   assign out_i   = out_valid ? mem_i[rd_idx] : '0;
   assign out_bin = out_valid ? bin_k : 3'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         cnt       <= '0;
         k         <= '0;
         stage     <= '0;
         j         <= '0;
         pend_v    <= 1'b0;
         pend_a    <= '0;
         pend_b    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         bf_start  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= '0;
            mem_i[i] <= '0;
         end
         tw_r[0] <= DW'(1); tw_i[0] <= '0;
         tw_r[1] <= DW'(1); tw_i[1] <= '1;
         tw_r[2] <= '0;     tw_i[2] <= '1;
         tw_r[3] <= '1;     tw_i[3] <= '1;
      end else begin
         // Table only changes between frames, before the first sample lands.
         if (tw_we && state == LOAD && cnt == 3'd0) begin
            tw_r[tw_addr] <= tw_wr_r;
            tw_i[tw_addr] <= tw_wr_i;
         end
         if (pend_v) begin
            mem_r[pend_a] <= bf_y1_r;
            mem_i[pend_a] <= bf_y1_i;
            mem_r[pend_b] <= bf_y2_r;
            mem_i[pend_b] <= bf_y2_i;
         end
         pend_v <= bf_start;
         pend_a <= ia;
         pend_b <= ib;
         case (state)
            LOAD: if (in_valid && in_ready) begin
               mem_r[cnt] <= in_r;
               mem_i[cnt] <= in_i;
               cnt        <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state    <= RUN;
                  stage    <= '0;
                  j        <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  bf_start <= 1'b1;
               end
            end
            RUN: begin
               j <= j + 2'd1;
               if (j == 2'd3) begin
                  state    <= DRAIN;
                  bf_start <= 1'b0;
               end
            end
            DRAIN: begin
               if (stage == 2'd2) begin
                  state     <= OUT;
                  k         <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
               end else begin
                  stage    <= stage + 2'd1;
                  state    <= RUN;
                  bf_start <= 1'b1;
               end
            end
            OUT: if (out_ready) begin
               if (k == 3'd7) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  k        <= k + 3'd1;
                  out_last <= (k == 3'd6);
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Scoreboard bench for fft8_seq_ctrl with a behavioural registered butterfly on the bf_* ports.
module tb_fft8_seq_ctrl;
   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [15:0] in_r, in_i, out_r, out_i;
   logic [2:0]  out_bin;
   logic        tw_we;
   logic [1:0]  tw_addr;
   logic [15:0] tw_wr_r, tw_wr_i;
   logic        bf_start;
   logic [15:0] bf_x1_r, bf_x1_i, bf_x2_r, bf_x2_i, bf_w_r, bf_w_i;
   logic [15:0] bf_y1_r, bf_y1_i, bf_y2_r, bf_y2_i;

   fft8_seq_ctrl #(.DW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_bin(out_bin), .out_last(out_last), .busy(busy),
      .tw_we(tw_we), .tw_addr(tw_addr), .tw_wr_r(tw_wr_r), .tw_wr_i(tw_wr_i),
      .bf_start(bf_start),
      .bf_x1_r(bf_x1_r), .bf_x1_i(bf_x1_i), .bf_x2_r(bf_x2_r), .bf_x2_i(bf_x2_i),
      .bf_w_r(bf_w_r), .bf_w_i(bf_w_i),
      .bf_y1_r(bf_y1_r), .bf_y1_i(bf_y1_i), .bf_y2_r(bf_y2_r), .bf_y2_i(bf_y2_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered DIF butterfly: y1 = x1+x2, y2 = (x1-x2)*w, all wrapping to 16 bits.
   logic [15:0] dr, di;
   assign dr = bf_x1_r - bf_x2_r;
   assign di = bf_x1_i - bf_x2_i;
   always @(posedge clk) begin
      if (bf_start) begin
         bf_y1_r <= bf_x1_r + bf_x2_r;
         bf_y1_i <= bf_x1_i + bf_x2_i;
         bf_y2_r <= dr * bf_w_r - di * bf_w_i;
         bf_y2_i <= dr * bf_w_i + di * bf_w_r;
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct { logic [2:0] bin; logic [15:0] r, i; logic last; } exp_t;
   exp_t sb[$];

`ifdef FFT8_NATURAL_ORDER_EN
   localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
   localparam int ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif

   // Monitor: pops on every output handshake, and checks hold stability while stalled.
   exp_t        me;
   logic        stalled = 1'b0;
   logic [15:0] p_r, p_i;
   logic [2:0]  p_bin;
   int          hs = 0;
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (stalled) begin
            chk("hold_r", out_r, p_r);
            chk("hold_i", out_i, p_i);
            chk("hold_bin", out_bin, p_bin);
         end
         if (out_ready) begin
            hs++;
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               me = sb.pop_front();
               chk("out_bin", out_bin, me.bin);
               chk("out_r", out_r, me.r);
               chk("out_i", out_i, me.i);
               chk("out_last", out_last, me.last);
            end
         end
         stalled = !out_ready;
         p_r = out_r; p_i = out_i; p_bin = out_bin;
      end else stalled = 1'b0;
   end

   int bf_cnt = 0;
   always @(negedge clk) if (bf_start) bf_cnt++;

   task automatic push_frame(input logic [7:0][15:0] er, input logic [7:0][15:0] ei);
      exp_t e;
      for (int s = 0; s < 8; s++) begin
         e.bin  = 3'(ORD[s]);
         e.r    = er[ORD[s]];
         e.i    = ei[ORD[s]];
         e.last = (s == 7);
         sb.push_back(e);
      end
   endtask

   task automatic load(input logic [7:0][15:0] xr);
      for (int n = 0; n < 8; n++) begin
         in_valid = 1'b1;
         in_r     = xr[n];
         in_i     = 16'd0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit bp);
      int t = 0;
      while (sb.size() != 0 && t < 400) begin
         if (bp) out_ready = (t % 4 == 0) || (t % 4 == 3);
         @(posedge clk); #1;
         t++;
      end
      out_ready = 1'b1;
      chk("frame_done_in_time", (t < 400), 1);
      chk("in_ready_after", in_ready, 1);
      chk("busy_after", busy, 0);
   endtask

   logic [7:0][15:0] imp0, imp4, dc, ones, zeros, alt, dc_out;
   int lat;
   bit found;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b1;
      tw_we = 1'b0; tw_addr = '0; tw_wr_r = '0; tw_wr_i = '0;
      zeros = '0;
      imp0 = '0; imp0[0] = 16'd1;
      imp4 = '0; imp4[4] = 16'd1;
      for (int n = 0; n < 8; n++) begin
         dc[n]   = 16'd1;
         ones[n] = 16'd1;
         alt[n]  = n[0] ? 16'hFFFF : 16'd1;
      end
      dc_out = '0; dc_out[0] = 16'd8;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bf_start", bf_start, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_r", out_r, 0);

      // Impulse at x[0]: flat spectrum
      push_frame(ones, zeros);
      load(imp0);
      wait_done(0);

      // DC frame with latency and issue count
      bf_cnt = 0;
      push_frame(dc_out, zeros);
      load(dc);
      lat = 0; found = 0;
      for (int c = 1; c <= 20 && !found; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin found = 1; lat = c; end
      end
      chk("first_out_latency", lat, 15);
      wait_done(0);
      chk("bf_start_cycles", bf_cnt, 12);

      // Alternating-sign spectrum under backpressure
      hs = 0;
      push_frame(alt, zeros);
      load(imp4);
      wait_done(1);
      chk("handshakes", hs, 8);

      // Twiddle programming in idle, then an ignored write mid-RUN
      tw_we = 1'b1; tw_addr = 2'd1; tw_wr_r = 16'd0; tw_wr_i = 16'd1;
      @(posedge clk); #1;
      tw_we = 1'b0;
      push_frame(ones, zeros);
      load(imp0);
      @(posedge clk); #1;
      chk("tw_issue1_start", bf_start, 1);
      chk("tw_w1_r", bf_w_r, 16'd0);
      chk("tw_w1_i", bf_w_i, 16'd1);
      tw_we = 1'b1; tw_addr = 2'd1; tw_wr_r = 16'd7; tw_wr_i = 16'd7;
      @(posedge clk); #1;
      tw_we = 1'b0;
      wait_done(0);
      push_frame(ones, zeros);
      load(imp0);
      @(posedge clk); #1;
      chk("tw_kept_r", bf_w_r, 16'd0);
      chk("tw_kept_i", bf_w_i, 16'd1);
      wait_done(0);

      // Async reset in stage 1, then a clean DC frame
      load(dc);
      repeat (6) begin @(posedge clk); #1; end
      chk("mid_run_start", bf_start, 1);
      chk("mid_run_x1", bf_x1_r, 16'd2);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_bf_start", bf_start, 0);
      chk("arst_bf_x1", bf_x1_r, 0);
      chk("arst_bf_w", bf_w_r, 0);
      chk("arst_out_valid", out_valid, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      push_frame(dc_out, zeros);
      load(dc);
      wait_done(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
